// File: rtl/check_p_clock.sv
// check_p_clock: decides whether two observed clocks carry the same waveform.
// Both clocks are treated as data and sampled in the local `clock` domain.
// After reset the checker waits SETTLE cycles, then measures for WINDOW cycles.
// It then latches a sticky done/same verdict that holds until the next reset.
`timescale 1ns/1ps

module check_p_clock #(
    parameter int SETTLE = 16,
    parameter int WINDOW = 256,
    parameter int TOL    = 0
) (
    input  logic clock,
    input  logic rst_n,
    input  logic aclk,
    input  logic bclk,
    output logic done,
    output logic same
);

    localparam int CW = $clog2(SETTLE + WINDOW + 1);
    localparam int EW = $clog2(WINDOW + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] WINDOW_LAST = CW'(WINDOW - 1);
    // Clamp the tolerance to the counter range so the compare never truncates.
    localparam logic [EW-1:0] TOL_CAP = (TOL >= (2 ** EW) - 1) ? {EW{1'b1}} : EW'(TOL);

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_MEASURE,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [EW-1:0] mis_q, mis_d;
    logic [EW-1:0] edge_a_q, edge_a_d;
    logic [EW-1:0] edge_b_q, edge_b_d;
    logic          done_d, same_d;

    logic a_meta, b_meta;
    logic sa, sb;
    logic pa, pb;
    logic rise_a, rise_b;

    // Two-flop synchronizers plus a previous-value stage, identical on both paths.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            a_meta <= 1'b0;
            b_meta <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            pa     <= 1'b0;
            pb     <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage takes the pre-edge value of the one before;
            // blocking assignments would collapse the chain into a single flop.
            a_meta <= aclk;
            b_meta <= bclk;
            sa     <= a_meta;
            sb     <= b_meta;
            pa     <= sa;
            pb     <= sb;
        end
    end

    assign rise_a = sa & ~pa;
    assign rise_b = sb & ~pb;

    // State, counters and the registered verdict.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SETTLE;
            cnt_q    <= '0;
            mis_q    <= '0;
            edge_a_q <= '0;
            edge_b_q <= '0;
            done     <= 1'b0;
            same     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mis_q    <= mis_d;
            edge_a_q <= edge_a_d;
            edge_b_q <= edge_b_d;
            done     <= done_d;
            same     <= same_d;
        end
    end

    // Next-state logic: settle, measure, then freeze everything in DONE.
    always_comb begin
        // NOTE: every output gets a hold default first, so no path leaves one unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        mis_d    = mis_q;
        edge_a_d = edge_a_q;
        edge_b_d = edge_b_q;
        done_d   = done;
        same_d   = same;
        case (state_q)
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_MEASURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_MEASURE: begin
                cnt_d = cnt_q + CW'(1);
                if ((sa != sb) && (mis_q != {EW{1'b1}})) mis_d = mis_q + EW'(1);
                if (rise_a) edge_a_d = edge_a_q + EW'(1);
                if (rise_b) edge_b_d = edge_b_q + EW'(1);
                if (cnt_q == WINDOW_LAST) begin
                    // The verdict includes this final cycle's updates.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    same_d  = (mis_d <= TOL_CAP) && (edge_a_d == edge_b_d) && (edge_a_d != '0);
                end
            end
            default: begin
                // DONE: counters and outputs hold until reset.
            end
        endcase
    end

endmodule

// File: tb/tb_check_p_clock.sv
// Testbench for check_p_clock. Random waveform pairs drive two checkers that
// differ only in TOL. A reference model derives the verdict from the
// waveforms. A monitor compares the done timing and the verdict against a
// scoreboard queue.
`timescale 1ns/1ps

module tb_check_p_clock;

    localparam int S    = 16;
    localparam int W    = 256;
    localparam int N    = S + W;
    localparam int MAXC = N + 1100;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic aclk  = 1'b0;
    logic bclk  = 1'b0;
    logic done0, same0, done2, same2;

    check_p_clock #(.SETTLE(S), .WINDOW(W), .TOL(0)) dut0 (
        .clock(clock), .rst_n(rst_n), .aclk(aclk), .bclk(bclk), .done(done0), .same(same0)
    );

    check_p_clock #(.SETTLE(S), .WINDOW(W), .TOL(2)) dut2 (
        .clock(clock), .rst_n(rst_n), .aclk(aclk), .bclk(bclk), .done(done2), .same(same2)
    );

    always #1 clock = ~clock;

    typedef struct {
        int cyc;
        bit same_t0;
        bit same_t2;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   done_seen = 1'b0;
    exp_t held;
    int   cyc = 0;

    // Input levels captured at clock edge k after reset release (k >= 1).
    bit av[MAXC+1];
    bit bv[MAXC+1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit clk_lv(int k, int hp, int ph);
        return bit'(((k + ph) / hp) % 2);
    endfunction

    function automatic bit lv_a(int k);
        return (k < 1) ? 1'b0 : av[k];
    endfunction

    function automatic bit lv_b(int k);
        return (k < 1) ? 1'b0 : bv[k];
    endfunction

    // Waveform pair per scenario: 0 identical, 1 inverted, 2 half rate, 3 stuck low,
    // 4 one-cycle late fall on B, 5 one-cycle flip on B, 6 unrelated rates, 7 noise.
    task automatic build(input int mode);
        int hp  = int'($urandom_range(1, 6));
        int ph  = int'($urandom_range(0, 2 * hp - 1));
        int hp2 = (hp % 6) + 1;
        int gk;
        for (int k = 1; k <= MAXC; k++) begin
            av[k] = clk_lv(k, hp, ph);
            bv[k] = av[k];
        end
        case (mode)
            1: for (int k = 1; k <= MAXC; k++) bv[k] = ~av[k];
            2: for (int k = 1; k <= MAXC; k++) bv[k] = clk_lv(k, 2 * hp, ph);
            3: for (int k = 1; k <= MAXC; k++) begin
                av[k] = 1'b0;
                bv[k] = 1'b0;
            end
            4: begin
                gk = S + 10 + int'($urandom_range(0, 100));
                while (!(av[gk-1] && !av[gk])) gk++;
                bv[gk] = 1'b1;
            end
            5: begin
                gk = int'($urandom_range(S + 10, N - 20));
                bv[gk] = ~bv[gk];
            end
            6: for (int k = 1; k <= MAXC; k++) bv[k] = clk_lv(k, hp2, 0);
            7: for (int k = 1; k <= MAXC; k++) begin
                av[k] = bit'($urandom_range(0, 1));
                bv[k] = ($urandom_range(0, 63) == 0) ? ~av[k] : av[k];
            end
            default: ;
        endcase
    endtask

    // Reference: the measured value at edge m is the input captured two edges earlier.
    function automatic exp_t model();
        exp_t e;
        int   mis = 0;
        int   ea  = 0;
        int   eb  = 0;
        for (int m = S + 1; m <= N; m++) begin
            if (lv_a(m - 2) != lv_b(m - 2)) mis++;
            if (lv_a(m - 2) && !lv_a(m - 3)) ea++;
            if (lv_b(m - 2) && !lv_b(m - 3)) eb++;
        end
        e.cyc     = N;
        e.same_t0 = (mis <= 0) && (ea == eb) && (ea != 0);
        e.same_t2 = (mis <= 2) && (ea == eb) && (ea != 0);
        return e;
    endfunction

    // One measurement: async reset, optional abort after abort_at cycles, else run to done plus tail.
    task automatic run(input int mode, input int abort_at, input int tail);
        exp_t e;
        int   limit;
        build(mode);
        e = model();
        @(negedge clock);
        #0.3 rst_n = 1'b0;
        #0.2;
        check("reset_done_tol0", done0, 0);
        check("reset_same_tol0", same0, 0);
        check("reset_done_tol2", done2, 0);
        check("reset_same_tol2", same2, 0);
        repeat (3) @(negedge clock);
        if (abort_at == 0) exp_q.push_back(e);
        rst_n = 1'b1;
        aclk  = av[1];
        bclk  = bv[1];
        limit = (abort_at > 0) ? abort_at : N + tail;
        for (int k = 2; k <= limit; k++) begin
            @(negedge clock);
            aclk = av[k];
            bclk = bv[k];
            if (abort_at == 0 && k == N + 4) begin
                check("done_by_deadline", done_seen, 1);
                if (!done_seen && exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    endtask

    // Monitor: counts edges since reset release and checks outputs just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #0.5;
            if (!rst_n) begin
                cyc       = 0;
                done_seen = 1'b0;
            end else begin
                cyc++;
                if (!done_seen) begin
                    if (done0 || done2) begin
                        done_seen = 1'b1;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done: done rose at cycle %0d with no run pending", cyc);
                            held.cyc     = cyc;
                            held.same_t0 = same0;
                            held.same_t2 = same2;
                        end else begin
                            e = exp_q.pop_front();
                            check("done_cycle", cyc, e.cyc);
                            check("done_tol0", done0, 1);
                            check("done_tol2", done2, 1);
                            check("same_tol0", same0, e.same_t0);
                            check("same_tol2", same2, e.same_t2);
                            held = e;
                        end
                    end else begin
                        check("same_before_done_tol0", same0, 0);
                        check("same_before_done_tol2", same2, 0);
                    end
                end else begin
                    check("hold_done_tol0", done0, 1);
                    check("hold_done_tol2", done2, 1);
                    check("hold_same_tol0", same0, held.same_t0);
                    check("hold_same_tol2", same2, held.same_t2);
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clock);
        for (int m = 0; m < 8; m++) run(m, 0, 8);
        for (int i = 0; i < 6; i++) run(int'($urandom_range(0, 7)), 0, 8);
        run(4, 0, 8);
        run(0, 100, 0);
        run(0, 0, 1000);
        @(negedge clock);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
